// File: rtl/carrack_pkg.sv
// Shared constants for the Carrack fastio register block: pad width,
// register offsets, CNT_CTRL field positions and the default ID word.
package carrack_pkg;

    localparam int FASTIO_W = 28;

    // Word offsets (byte address bits [4:2]) within the 32-byte window
    localparam logic [2:0] REG_OUT      = 3'd0;
    localparam logic [2:0] REG_OE       = 3'd1;
    localparam logic [2:0] REG_MED      = 3'd2;
    localparam logic [2:0] REG_STRONG   = 3'd3;
    localparam logic [2:0] REG_IN       = 3'd4;
    localparam logic [2:0] REG_CNT_CTRL = 3'd5;
    localparam logic [2:0] REG_CNT_VAL  = 3'd6;
    localparam logic [2:0] REG_ID       = 3'd7;

    localparam int CTRL_SEL_LSB = 0;
    localparam int CTRL_SEL_W   = 5;
    localparam int CTRL_EN_BIT  = 8;
    localparam int CTRL_CLR_BIT = 9;

    localparam logic [31:0] ID_DEFAULT = 32'hCA77_AC01;

    function automatic logic [FASTIO_W-1:0] merge_field(
        input logic [FASTIO_W-1:0] old_val,
        input logic [FASTIO_W-1:0] wdat,
        input logic [3:0]          be
    );
        logic [FASTIO_W-1:0] res;
        for (int i = 0; i < FASTIO_W; i++) begin
            res[i] = be[i / 8] ? wdat[i] : old_val[i];
        end
        return res;
    endfunction

endpackage

// File: rtl/carrack_edge_counter.sv
// Saturating rising-edge counter on one selectable synchronized fastio input.
// Only instantiated when CARRACK_EDGE_COUNTER_EN is defined.
module carrack_edge_counter
    import carrack_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [FASTIO_W-1:0]   sync_in,
    input  logic [CTRL_SEL_W-1:0] cnt_sel,
    input  logic                  cnt_en,
    input  logic                  ctrl_wr,
    input  logic                  clr,
    output logic [31:0]           count
);

    logic [31:0] padded;
    logic        sel_bit;
    logic        prev_bit;
    logic        suppress;
    logic        rise;

    // Selections beyond the last pad land on the zero padding and never toggle
    always_comb begin
        padded  = {{(32 - FASTIO_W){1'b0}}, sync_in};
        sel_bit = padded[cnt_sel];
        rise    = sel_bit & ~prev_bit & ~suppress;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_bit <= 1'b0;
            suppress <= 1'b0;
            count    <= 32'd0;
        end else begin
            prev_bit <= sel_bit;
            suppress <= ctrl_wr;
            if (clr) begin
                count <= 32'd0;
            end else if (cnt_en && rise && (count != 32'hFFFF_FFFF)) begin
                count <= count + 32'd1;
            end
        end
    end

endmodule

// File: rtl/carrack_fastio_regs.sv
// Wishbone register window for the 28 Carrack fastio pads. The optional edge
// counter is built only when CARRACK_EDGE_COUNTER_EN is defined.
module carrack_fastio_regs
    import carrack_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter logic [31:0] ID_VALUE  = ID_DEFAULT
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    input  logic                wbs_stb_i,
    input  logic                wbs_cyc_i,
    input  logic                wbs_we_i,
    input  logic [3:0]          wbs_sel_i,
    input  logic [31:0]         wbs_adr_i,
    input  logic [31:0]         wbs_dat_i,
    output logic                wbs_ack_o,
    output logic [31:0]         wbs_dat_o,
    input  logic [FASTIO_W-1:0] fastio_in,
    output logic [FASTIO_W-1:0] fastio_out_l,
    output logic [FASTIO_W-1:0] fastio_oe_l,
    output logic [FASTIO_W-1:0] fastio_med_enable,
    output logic [FASTIO_W-1:0] fastio_strong_enable
);

    logic [FASTIO_W-1:0] sync_s1, sync_s2;
    logic [FASTIO_W-1:0] out_q, oe_q, med_q, strong_q;
    logic                hit, req, wr;
    logic                pend_we;
    logic [2:0]          pend_reg;
    logic [31:0]         pend_dat;
    logic [3:0]          pend_sel;
    logic [31:0]         ctrl_rd, cnt_rd, rdata;
    logic                unused_bits;

    for (genvar i = 0; i < FASTIO_W; i++) begin : g_sync
        always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
            if (wb_rst_i) begin
                sync_s1[i] <= 1'b0;
                sync_s2[i] <= 1'b0;
            end else begin
                sync_s1[i] <= fastio_in[i];
                sync_s2[i] <= sync_s1[i];
            end
        end
    end

    // Handshake: a selected request is accepted only while ack is low; ack is
    // high for exactly the next cycle and low the one after, so a held strobe
    // completes one access every two cycles. The write commits at the ack edge.
    always_comb begin
        hit = wbs_stb_i & wbs_cyc_i & (wbs_adr_i[31:5] == BASE_ADDR[31:5]);
        req = hit & ~wbs_ack_o;
        wr  = wbs_ack_o & pend_we;
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= 32'd0;
            pend_we   <= 1'b0;
            pend_reg  <= 3'd0;
            pend_dat  <= 32'd0;
            pend_sel  <= 4'd0;
        end else begin
            wbs_ack_o <= req;
            wbs_dat_o <= req ? rdata : 32'd0;
            if (req) begin
                pend_we  <= wbs_we_i;
                pend_reg <= wbs_adr_i[4:2];
                pend_dat <= wbs_dat_i;
                pend_sel <= wbs_sel_i;
            end else if (wbs_ack_o) begin
                pend_we  <= 1'b0;
            end
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            out_q    <= '0;
            oe_q     <= '0;
            med_q    <= '0;
            strong_q <= '0;
        end else if (wr) begin
            case (pend_reg)
                REG_OUT:    out_q    <= merge_field(out_q,    pend_dat[FASTIO_W-1:0], pend_sel);
                REG_OE:     oe_q     <= merge_field(oe_q,     pend_dat[FASTIO_W-1:0], pend_sel);
                REG_MED:    med_q    <= merge_field(med_q,    pend_dat[FASTIO_W-1:0], pend_sel);
                REG_STRONG: strong_q <= merge_field(strong_q, pend_dat[FASTIO_W-1:0], pend_sel);
                default: ;
            endcase
        end
    end

`ifdef CARRACK_EDGE_COUNTER_EN
    logic [CTRL_SEL_W-1:0] ctrl_sel;
    logic                  ctrl_en;
    logic                  ctrl_wr;
    logic                  ctrl_clr;
    logic [31:0]           cnt_val;

    always_comb begin
        ctrl_wr  = wr & (pend_reg == REG_CNT_CTRL);
        ctrl_clr = ctrl_wr & pend_sel[1] & pend_dat[CTRL_CLR_BIT];
        ctrl_rd  = 32'd0;
        ctrl_rd[CTRL_SEL_LSB +: CTRL_SEL_W] = ctrl_sel;
        ctrl_rd[CTRL_EN_BIT] = ctrl_en;
        cnt_rd   = cnt_val;
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            ctrl_sel <= '0;
            ctrl_en  <= 1'b0;
        end else if (ctrl_wr) begin
            if (pend_sel[0]) ctrl_sel <= pend_dat[CTRL_SEL_LSB +: CTRL_SEL_W];
            if (pend_sel[1]) ctrl_en  <= pend_dat[CTRL_EN_BIT];
        end
    end

    carrack_edge_counter u_edge_counter (
        .clk     (wb_clk_i),
        .rst     (wb_rst_i),
        .sync_in (sync_s2),
        .cnt_sel (ctrl_sel),
        .cnt_en  (ctrl_en),
        .ctrl_wr (ctrl_wr),
        .clr     (ctrl_clr),
        .count   (cnt_val)
    );
`else
    always_comb begin
        ctrl_rd = 32'd0;
        cnt_rd  = 32'd0;
    end
`endif

    always_comb begin
        rdata = 32'd0;
        case (wbs_adr_i[4:2])
            REG_OUT:      rdata[FASTIO_W-1:0] = out_q;
            REG_OE:       rdata[FASTIO_W-1:0] = oe_q;
            REG_MED:      rdata[FASTIO_W-1:0] = med_q;
            REG_STRONG:   rdata[FASTIO_W-1:0] = strong_q;
            REG_IN:       rdata[FASTIO_W-1:0] = sync_s2;
            REG_CNT_CTRL: rdata = ctrl_rd;
            REG_CNT_VAL:  rdata = cnt_rd;
            default:      rdata = ID_VALUE;
        endcase
    end

    assign fastio_out_l         = out_q;
    assign fastio_oe_l          = oe_q;
    assign fastio_med_enable    = med_q;
    assign fastio_strong_enable = strong_q;

    assign unused_bits = ^{wbs_adr_i[1:0], pend_dat[31:FASTIO_W]};

endmodule

// File: tb/tb_carrack_fastio_regs.sv
// Randomized self-checking bench for carrack_fastio_regs against a
// cycle-level behavioural model of the register window and edge counter.
module tb_carrack_fastio_regs;

    localparam logic [31:0] BASE  = 32'h3000_0000;
    localparam logic [31:0] ID_EXP = 32'hCA77_AC01;

`ifdef CARRACK_EDGE_COUNTER_EN
    localparam bit COUNTER_ON = 1'b1;
`else
    localparam bit COUNTER_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stb = 1'b0, cyc = 1'b0, we = 1'b0;
    logic [3:0]  sel = 4'd0;
    logic [31:0] adr = 32'd0, wdat = 32'd0;
    logic        ack;
    logic [31:0] rdat;
    logic [27:0] pads = 28'd0;
    logic [27:0] pad_out, pad_oe, pad_med, pad_strong;

    carrack_fastio_regs dut (
        .wb_clk_i             (clk),
        .wb_rst_i             (rst),
        .wbs_stb_i            (stb),
        .wbs_cyc_i            (cyc),
        .wbs_we_i             (we),
        .wbs_sel_i            (sel),
        .wbs_adr_i            (adr),
        .wbs_dat_i            (wdat),
        .wbs_ack_o            (ack),
        .wbs_dat_o            (rdat),
        .fastio_in            (pads),
        .fastio_out_l         (pad_out),
        .fastio_oe_l          (pad_oe),
        .fastio_med_enable    (pad_med),
        .fastio_strong_enable (pad_strong)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [27:0] m_out = '0, m_oe = '0, m_med = '0, m_strong = '0;
    logic [4:0]  m_sel = '0;
    logic        m_en = 1'b0, m_sup = 1'b0;
    logic [31:0] m_cnt = '0, m_cnt_during = '0;
    logic [27:0] pad_hist[$];
    logic        p_ctrl = 1'b0;
    logic [31:0] p_dat = '0;
    logic [3:0]  p_be = '0;
    logic        exp_ack = 1'b0;
    bit          rand_pads = 1'b0;

    function automatic logic [27:0] bmerge(input logic [27:0] old_v, input logic [31:0] d, input logic [3:0] be);
        logic [31:0] w;
        w = {4'd0, old_v};
        for (int b = 0; b < 4; b++) if (be[b]) w[8*b +: 8] = d[8*b +: 8];
        return w[27:0];
    endfunction

    // pad_hist[0] holds the pad value of the cycle just ended; the value seen
    // through the two-stage synchronizer in that cycle is pad_hist[2].
    always @(posedge clk) begin
        if (rst) begin
            pad_hist     = '{28'd0, 28'd0, 28'd0, 28'd0};
            m_cnt        = 0;
            m_cnt_during = 0;
            m_sup        = 0;
            m_sel        = 0;
            m_en         = 0;
            p_ctrl       = 0;
        end else begin
            pad_hist.push_front(pads);
            if (pad_hist.size() > 8) void'(pad_hist.pop_back());
            m_cnt_during = m_cnt;
            if (m_en && !m_sup && m_sel < 28 && m_cnt != 32'hFFFF_FFFF) begin
                if (pad_hist[2][m_sel] && !pad_hist[3][m_sel]) m_cnt = m_cnt + 1;
            end
            m_sup = 0;
            if (p_ctrl) begin
                if (p_be[0]) m_sel = p_dat[4:0];
                if (p_be[1]) begin
                    m_en = p_dat[8];
                    if (p_dat[9]) m_cnt = 0;
                end
                m_sup  = 1;
                p_ctrl = 0;
            end
        end
    end

    // Per-cycle comparison of every output against the model
    always @(negedge clk) begin
        if (!rst) begin
            check("pad_out", {4'd0, pad_out}, {4'd0, m_out});
            check("pad_oe", {4'd0, pad_oe}, {4'd0, m_oe});
            check("pad_med", {4'd0, pad_med}, {4'd0, m_med});
            check("pad_strong", {4'd0, pad_strong}, {4'd0, m_strong});
            check("ack_cycle", {31'd0, ack}, {31'd0, exp_ack});
            if (!ack) check("dat_idle", rdat, 32'd0);
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_pads) pads = 28'($urandom);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic model_reset_regs();
        m_out = '0; m_oe = '0; m_med = '0; m_strong = '0;
        exp_ack = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset_regs();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic wb_access(input logic w, input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] be, output logic [31:0] rd);
        logic        hit;
        logic [31:0] exp;
        logic        seen;
        hit = (a[31:5] == BASE[31:5]);
        @(posedge clk);
        #1;
        stb = 1'b1; cyc = 1'b1; we = w; adr = a; wdat = d; sel = be;
        @(posedge clk);
        #1;
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
        rd = 32'd0;
        if (!hit) begin
            seen = 1'b0;
            for (int c = 0; c < 8; c++) begin
                @(negedge clk);
                if (ack) seen = 1'b1;
            end
            check("oow_no_ack", {31'd0, seen}, 32'd0);
            return;
        end
        case (a[4:2])
            3'd0: exp = {4'd0, m_out};
            3'd1: exp = {4'd0, m_oe};
            3'd2: exp = {4'd0, m_med};
            3'd3: exp = {4'd0, m_strong};
            3'd4: exp = {4'd0, pad_hist[2]};
            3'd5: exp = COUNTER_ON ? {23'd0, m_en, 3'd0, m_sel} : 32'd0;
            3'd6: exp = COUNTER_ON ? m_cnt_during : 32'd0;
            default: exp = ID_EXP;
        endcase
        if (w && a[4:2] == 3'd5) begin
            p_ctrl = 1'b1; p_dat = d; p_be = be;
        end
        exp_ack = 1'b1;
        @(negedge clk);
        check("ack_latency", {31'd0, ack}, 32'd1);
        rd = rdat;
        if (!w) check("read_data", rdat, exp);
        @(posedge clk);
        #1;
        exp_ack = 1'b0;
        if (w) begin
            case (a[4:2])
                3'd0: m_out    = bmerge(m_out, d, be);
                3'd1: m_oe     = bmerge(m_oe, d, be);
                3'd2: m_med    = bmerge(m_med, d, be);
                3'd3: m_strong = bmerge(m_strong, d, be);
                default: ;
            endcase
        end
    endtask

    // ---------------- test sequence ----------------
    logic [31:0] rd;

    initial begin
        do_reset();
        @(negedge clk);
        check("reset_out", {4'd0, pad_out}, 32'd0);
        check("reset_oe", {4'd0, pad_oe}, 32'd0);
        check("reset_ack", {31'd0, ack}, 32'd0);

        wb_access(1'b0, BASE + 32'h1C, 32'd0, 4'hF, rd);
        check("id_literal", rd, 32'hCA77_AC01);

        wb_access(1'b1, BASE + 32'h04, 32'h0FFF_FFFF, 4'b0011, rd);
        @(negedge clk);
        check("oe_pads_literal", {4'd0, pad_oe}, 32'h0000_FFFF);
        wb_access(1'b0, BASE + 32'h04, 32'd0, 4'hF, rd);
        check("oe_read_literal", rd, 32'h0000_FFFF);

        @(posedge clk); #1 pads = 28'hA5A5A5A;
        repeat (4) @(posedge clk);
        wb_access(1'b0, BASE + 32'h10, 32'd0, 4'hF, rd);
        check("in_literal", rd, 32'h0A5A_5A5A);
        wb_access(1'b0, BASE + 32'h20, 32'd0, 4'hF, rd);

        @(posedge clk); #1 pads = 28'd0;
        repeat (4) @(posedge clk);
        wb_access(1'b1, BASE + 32'h14, 32'h0000_0103, 4'b0011, rd);
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1 pads[3] = ((c % 4) < 2);
        end
        @(posedge clk); #1 pads[3] = 1'b0;
        repeat (4) @(posedge clk);
        wb_access(1'b0, BASE + 32'h18, 32'd0, 4'hF, rd);
        check("cnt_10_pulses", rd, COUNTER_ON ? 32'd10 : 32'd0);

        @(posedge clk); #1 pads[4] = 1'b1;
        repeat (4) @(posedge clk);
        wb_access(1'b1, BASE + 32'h14, 32'h0000_0104, 4'b0011, rd);
        repeat (4) @(posedge clk);
        wb_access(1'b0, BASE + 32'h18, 32'd0, 4'hF, rd);
        check("cnt_sel_change", rd, COUNTER_ON ? 32'd10 : 32'd0);

        @(posedge clk); #1 pads[4] = 1'b0;
        repeat (4) @(posedge clk);
        @(posedge clk); #1 pads[4] = 1'b1;
        wb_access(1'b1, BASE + 32'h14, 32'h0000_0304, 4'b0011, rd);
        repeat (4) @(posedge clk);
        wb_access(1'b0, BASE + 32'h18, 32'd0, 4'hF, rd);
        check("cnt_clr_vs_edge", rd, 32'd0);

        // Held strobe: accesses complete every other cycle
        @(posedge clk);
        #1;
        stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = BASE + 32'h1C; sel = 4'hF;
        for (int c = 0; c < 6; c++) begin
            exp_ack = (c % 2 == 1);
            @(negedge clk);
            check("b2b_ack", {31'd0, ack}, (c % 2 == 1) ? 32'd1 : 32'd0);
            if (c % 2 == 1) check("b2b_data", rdat, ID_EXP);
            @(posedge clk);
            #1;
        end
        stb = 1'b0; cyc = 1'b0;
        exp_ack = 1'b0;

        // Reset in the request cycle drops the write
        @(posedge clk);
        #1;
        stb = 1'b1; cyc = 1'b1; we = 1'b1; adr = BASE + 32'h00; wdat = 32'hFFFF_FFFF; sel = 4'hF;
        #2 rst = 1'b1;
        model_reset_regs();
        @(posedge clk);
        #1;
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
        @(negedge clk);
        check("rst_no_ack", {31'd0, ack}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_out_pads", {4'd0, pad_out}, 32'd0);
        wb_access(1'b0, BASE + 32'h00, 32'd0, 4'hF, rd);
        check("rst_out_read", rd, 32'd0);

        // Randomized traffic with toggling pads
        rand_pads = 1'b1;
        for (int t = 0; t < 250; t++) begin
            logic [31:0] a, d;
            logic [3:0]  be;
            logic        w;
            w  = $urandom_range(0, 1);
            be = 4'($urandom_range(0, 15));
            d  = $urandom;
            a  = BASE + {27'd0, 3'($urandom_range(0, 7)), 2'd0};
            if (a[4:2] == 3'd5) begin
                d = {22'($urandom), ($urandom_range(0, 7) == 0), 1'b1, 3'd0, 5'($urandom_range(0, 31))};
            end
            if ($urandom_range(0, 15) == 0) a = ($urandom_range(0, 1) == 0) ? BASE + 32'h20 : 32'h4000_0000;
            wb_access(w, a, d, be, rd);
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end
        rand_pads = 1'b0;
        repeat (4) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
